// File: rtl/serial_add_ctrl_if.sv
// Host-side request/result bundle for the bit-serial add sequencer.
// The host drives the operands and start; the sequencer returns status and result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;

  modport master (
    output start, a_in, b_in, cin_in,
    input  busy, done, sum_out, cout_out
  );

  modport slave (
    input  start, a_in, b_in, cin_in,
    output busy, done, sum_out, cout_out
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial operand sequencer for an external 1-bit full-adder cell: feeds one
// LSB-first bit pair per clock and assembles the returned sum bits into a result.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_add_ctrl_if.slave        host,
  output logic                    fa_a,
  output logic                    fa_b,
  output logic                    fa_cin,
  input  logic                    fa_sum,
  input  logic                    fa_cout
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             c_reg_r;
  logic [CNT_W-1:0] cnt_r;
  // Only the upper WIDTH-1 sum bits need holding; the newest bit comes straight from the cell.
  logic [WIDTH-2:0] s_sh_r;
  logic [WIDTH-1:0] s_next_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_out_r;
  logic             cout_out_r;
  logic             last_bit_s;

  assign s_next_s   = {fa_sum, s_sh_r};
  assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

  // The adder cell only ever sees register bits, so its inputs are glitch-free.
  assign fa_a   = a_sh_r[0];
  assign fa_b   = b_sh_r[0];
  assign fa_cin = c_reg_r;

  assign host.busy     = busy_r;
  assign host.done     = done_r;
  assign host.sum_out  = sum_out_r;
  assign host.cout_out = cout_out_r;

  // Sequencer FSM with operand shifters, carry register, bit counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      a_sh_r     <= {WIDTH{1'b0}};
      b_sh_r     <= {WIDTH{1'b0}};
      c_reg_r    <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      s_sh_r     <= {(WIDTH-1){1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sum_out_r  <= {WIDTH{1'b0}};
      cout_out_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (host.start) begin
            a_sh_r  <= host.a_in;
            b_sh_r  <= host.b_in;
            c_reg_r <= host.cin_in;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // start is deliberately ignored here so in-flight operands stay intact.
          c_reg_r <= fa_cout;
          s_sh_r  <= s_next_s[WIDTH-1:1];
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            sum_out_r  <= s_next_s;
            cout_out_r <= fa_cout;
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= ST_DONE;
          end else begin
            done_r     <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_RUN;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
          if (host.start) begin
            a_sh_r  <= host.a_in;
            b_sh_r  <= host.b_in;
            c_reg_r <= host.cin_in;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
